// File: rtl/axil_multi_ch_slave_pkg.sv
// rtl/axil_multi_ch_slave_pkg.sv - response codes and FSM state types for the multi-channel AXI-Lite slave
package axil_ising_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_COLLECT,
        WR_ISSUE,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/axil_multi_ch_slave_if.sv
// rtl/axil_multi_ch_slave_if.sv - AXI4-Lite bus bundle with master/slave views
interface axil_multi_ch_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_multi_ch_slave_ch_decode.sv
// rtl/axil_multi_ch_slave_ch_decode.sv - address to channel select / range / one-hot decoder
module axil_ch_decode #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2,
    parameter int CH_LSB  = 12,
    parameter int ADDR_W  = 32
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [CH_BITS-1:0] sel,
    output logic               in_range,
    output logic [NUM_CH-1:0]  onehot
);
    // Only the channel field matters here; the rest of the address is consumed elsewhere.
    logic unused_bits;
    assign unused_bits = ^{addr[ADDR_W-1:CH_LSB+CH_BITS], addr[CH_LSB-1:0]};

    assign sel      = addr[CH_LSB +: CH_BITS];
    assign in_range = int'(sel) < NUM_CH;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            onehot[i] = (int'(sel) == i);
        end
    end
endmodule

// File: rtl/axil_multi_ch_slave.sv
// rtl/axil_multi_ch_slave.sv - AXI4-Lite slave fanning out to NUM_CH register channels
module axil_multi_ch_slave
    import axil_ising_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2,
    parameter int CH_LSB  = 12,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    axil_multi_ch_slave_if.slave     s,
    output logic [NUM_CH-1:0]        ch_wr_en,
    output logic [CH_LSB-1:0]        ch_wr_addr,
    output logic [DATA_W-1:0]        ch_wr_data,
    output logic [DATA_W/8-1:0]      ch_wr_strb,
    output logic [NUM_CH-1:0]        ch_rd_en,
    output logic [CH_LSB-1:0]        ch_rd_addr,
    input  logic [NUM_CH-1:0]        ch_rd_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_rd_data
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wr_state_t             wr_state, wr_next;
    logic                  aw_held, w_held;
    logic [ADDR_W-1:0]     aw_addr;
    logic [DATA_W-1:0]     w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  aw_hs, w_hs;
    logic [CH_BITS-1:0]    unused_wr_sel;
    logic                  wr_in_range;
    logic [NUM_CH-1:0]     wr_onehot;

    rd_state_t             rd_state, rd_next;
    logic [ADDR_W-1:0]     ar_addr;
    logic [CNT_W-1:0]      rd_cnt;
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            rresp_q;
    logic [CH_BITS-1:0]    unused_rd_sel;
    logic                  rd_in_range;
    logic [NUM_CH-1:0]     rd_onehot;
    logic                  rd_valid_sel;
    logic [DATA_W-1:0]     rd_data_sel;

    axil_ch_decode #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .CH_LSB(CH_LSB), .ADDR_W(ADDR_W)) u_wr_dec (
        .addr(aw_addr), .sel(unused_wr_sel), .in_range(wr_in_range), .onehot(wr_onehot)
    );

    axil_ch_decode #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .CH_LSB(CH_LSB), .ADDR_W(ADDR_W)) u_rd_dec (
        .addr(ar_addr), .sel(unused_rd_sel), .in_range(rd_in_range), .onehot(rd_onehot)
    );

    assign s.awready  = (wr_state == WR_COLLECT) && !aw_held;
    assign s.wready   = (wr_state == WR_COLLECT) && !w_held;
    assign aw_hs      = s.awvalid && s.awready;
    assign w_hs       = s.wvalid && s.wready;
    assign s.bvalid   = (wr_state == WR_RESP);
    assign s.bresp    = (wr_state == WR_RESP && !wr_in_range) ? RESP_DECERR : RESP_OKAY;
    assign ch_wr_addr = aw_addr[CH_LSB-1:0];
    assign ch_wr_data = w_data;
    assign ch_wr_strb = w_strb;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_COLLECT;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s.awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s.wdata;
                w_strb <= s.wstrb;
            end
            if (wr_state == WR_RESP && s.bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_comb begin
        wr_next  = wr_state;
        ch_wr_en = '0;
        unique case (wr_state)
            WR_COLLECT: if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = WR_ISSUE;
            WR_ISSUE: begin
                ch_wr_en = wr_onehot;
                wr_next  = WR_RESP;
            end
            WR_RESP:    if (s.bready) wr_next = WR_COLLECT;
            default:    wr_next = WR_COLLECT;
        endcase
    end

    // Only the addressed channel may answer; anything else on ch_rd_valid is noise.
    always_comb begin
        rd_data_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_data_sel = rd_data_sel | (ch_rd_data[i*DATA_W +: DATA_W] & {DATA_W{rd_onehot[i]}});
        end
    end
    assign rd_valid_sel = |(ch_rd_valid & rd_onehot);

    assign s.arready  = (rd_state == RD_IDLE);
    assign s.rvalid   = (rd_state == RD_RESP);
    assign s.rdata    = rdata_q;
    assign s.rresp    = rresp_q;
    assign ch_rd_addr = ar_addr[CH_LSB-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            ar_addr  <= '0;
            rd_cnt   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            unique case (rd_state)
                RD_IDLE:  if (s.arvalid) ar_addr <= s.araddr;
                RD_ISSUE: begin
                    rd_cnt <= '0;
                    if (!rd_in_range) begin
                        rdata_q <= '0;
                        rresp_q <= RESP_DECERR;
                    end
                end
                RD_WAIT: begin
                    // Data arriving on the final counted cycle still wins over the timeout.
                    if (rd_valid_sel) begin
                        rdata_q <= rd_data_sel;
                        rresp_q <= RESP_OKAY;
                    end else if (rd_cnt == CNT_LAST) begin
                        rdata_q <= '0;
                        rresp_q <= RESP_SLVERR;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_next  = rd_state;
        ch_rd_en = '0;
        unique case (rd_state)
            RD_IDLE:  if (s.arvalid) rd_next = RD_ISSUE;
            RD_ISSUE: begin
                if (rd_in_range) begin
                    ch_rd_en = rd_onehot;
                    rd_next  = RD_WAIT;
                end else begin
                    rd_next  = RD_RESP;
                end
            end
            RD_WAIT:  if (rd_valid_sel || rd_cnt == CNT_LAST) rd_next = RD_RESP;
            RD_RESP:  if (s.rready) rd_next = RD_IDLE;
            default:  rd_next = RD_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axil_multi_ch_slave.sv
// tb/tb_axil_multi_ch_slave.sv - randomized self-checking bench for axil_multi_ch_slave
module tb_axil_multi_ch_slave;
    localparam int N_CH = 3;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_multi_ch_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    logic [N_CH-1:0]    ch_wr_en, ch_rd_en, ch_rd_valid;
    logic [11:0]        ch_wr_addr, ch_rd_addr;
    logic [31:0]        ch_wr_data;
    logic [3:0]         ch_wr_strb;
    logic [N_CH*32-1:0] ch_rd_data;

    axil_multi_ch_slave #(
        .NUM_CH(N_CH), .CH_BITS(2), .CH_LSB(12), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .s(bus),
        .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data),
        .ch_wr_strb(ch_wr_strb), .ch_rd_en(ch_rd_en), .ch_rd_addr(ch_rd_addr),
        .ch_rd_valid(ch_rd_valid), .ch_rd_data(ch_rd_data)
    );

    typedef struct {
        int          cyc;
        int          ch;
        logic [31:0] data;
    } ev_t;
    ev_t evq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          wr_en_cnt = 0, wr_en_cyc = 0;
    logic [2:0]  wr_en_val;
    logic [11:0] wr_addr_obs;
    logic [31:0] wr_data_obs;
    logic [3:0]  wr_strb_obs;
    int          rd_en_cnt = 0, rd_en_cyc = 0;
    logic [2:0]  rd_en_val;
    logic [11:0] rd_addr_obs;
    int          rd_lat_cfg = 0;
    logic [31:0] rd_data_cfg = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe channel strobes, then play the channel responder for this cycle.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (|ch_wr_en) begin
            wr_en_cnt++;
            wr_en_cyc   = cyc;
            wr_en_val   = ch_wr_en;
            wr_addr_obs = ch_wr_addr;
            wr_data_obs = ch_wr_data;
            wr_strb_obs = ch_wr_strb;
        end
        if (|ch_rd_en) begin
            rd_en_cnt++;
            rd_en_cyc   = cyc;
            rd_en_val   = ch_rd_en;
            rd_addr_obs = ch_rd_addr;
            if (rd_lat_cfg > 0)
                for (int i = 0; i < N_CH; i++)
                    if (ch_rd_en[i]) evq.push_back('{cyc + rd_lat_cfg, i, rd_data_cfg});
        end
        ch_rd_valid = '0;
        ch_rd_data  = {$urandom, $urandom, $urandom};
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].cyc == cyc) begin
                ch_rd_valid[evq[i].ch]          = 1'b1;
                ch_rd_data[evq[i].ch*32 +: 32]  = evq[i].data;
                evq.delete(i);
            end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int t, k, aw_k, w_k, cnt0, sel;
        bit aw_done, w_done, aw_will, w_will, wready_chk, in_rng;
        aw_done = 0; w_done = 0; wready_chk = 0; t = 0; aw_k = 0; w_k = 0;
        cnt0 = wr_en_cnt;
        sel = int'((addr >> 12) & 32'h3);
        in_rng = sel < N_CH;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        while (!(aw_done && w_done) && t < 100) begin
            bus.awvalid = !aw_done && (t >= aw_dly);
            bus.wvalid  = !w_done && (t >= w_dly);
            if (w_done && !aw_done && !wready_chk) begin
                check("wready_while_w_held", bus.wready, 0);
                wready_chk = 1;
            end
            aw_will = bus.awvalid && bus.awready;
            w_will  = bus.wvalid && bus.wready;
            tick();
            t++;
            if (aw_will) begin aw_done = 1; aw_k = cyc - 1; end
            if (w_will)  begin w_done = 1;  w_k = cyc - 1;  end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            return;
        end
        k = (aw_k > w_k) ? aw_k : w_k;
        t = 0;
        while (!bus.bvalid && t < 50) begin tick(); t++; end
        if (!bus.bvalid) begin
            check("bvalid_timeout", 0, 1);
            return;
        end
        check("bvalid_cycle", cyc, k + 2);
        check("bresp", bus.bresp, in_rng ? 2'b00 : 2'b11);
        check("wr_en_pulses", wr_en_cnt - cnt0, in_rng ? 1 : 0);
        if (in_rng) begin
            check("wr_en_onehot", wr_en_val, 3'b001 << sel);
            check("wr_en_cycle", wr_en_cyc, k + 1);
            check("wr_addr", wr_addr_obs, addr & 32'hFFF);
            check("wr_data", wr_data_obs, data);
            check("wr_strb", wr_strb_obs, strb);
        end
        repeat (b_dly) tick();
        check("bvalid_held", bus.bvalid, 1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("bvalid_cleared", bus.bvalid, 0);
        check("awready_back", bus.awready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int lat, input logic [31:0] data,
                           input int r_dly, input bit spur);
        int t, k, cnt0, sel, exp_cyc;
        bit done, ar_will, in_rng;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        done = 0; t = 0; k = 0;
        cnt0 = rd_en_cnt;
        sel = int'((addr >> 12) & 32'h3);
        in_rng = sel < N_CH;
        rd_lat_cfg = lat; rd_data_cfg = data;
        bus.araddr = addr; bus.arvalid = 1'b1;
        while (!done && t < 100) begin
            ar_will = bus.arvalid && bus.arready;
            tick();
            t++;
            if (ar_will) begin done = 1; k = cyc - 1; end
        end
        bus.arvalid = 1'b0;
        if (!done) begin
            check("ar_handshake_timeout", 0, 1);
            return;
        end
        if (spur && in_rng) evq.push_back('{k + 2, (sel + 1) % N_CH, $urandom});
        // Reference: decode error, data within the timeout window, or timeout.
        if (!in_rng) begin
            exp_cyc = k + 2; exp_resp = 2'b11; exp_data = '0;
        end else if (lat >= 1 && lat <= TO) begin
            exp_cyc = k + lat + 2; exp_resp = 2'b00; exp_data = data;
        end else begin
            exp_cyc = k + TO + 2; exp_resp = 2'b10; exp_data = '0;
        end
        t = 0;
        while (!bus.rvalid && t < 60) begin tick(); t++; end
        if (!bus.rvalid) begin
            check("rvalid_timeout", 0, 1);
            return;
        end
        check("rvalid_cycle", cyc, exp_cyc);
        check("rresp", bus.rresp, exp_resp);
        check("rdata", bus.rdata, exp_data);
        check("rd_en_pulses", rd_en_cnt - cnt0, in_rng ? 1 : 0);
        if (in_rng) begin
            check("rd_en_onehot", rd_en_val, 3'b001 << sel);
            check("rd_en_cycle", rd_en_cyc, k + 1);
            check("rd_addr", rd_addr_obs, addr & 32'hFFF);
        end
        repeat (r_dly) tick();
        check("rvalid_held", bus.rvalid, 1);
        check("rdata_stable", bus.rdata, exp_data);
        check("rresp_stable", bus.rresp, exp_resp);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("rvalid_cleared", bus.rvalid, 0);
        rd_lat_cfg = 0;
        t = 0;
        while (evq.size() > 0 && t < 40) begin tick(); t++; end
    endtask

    initial begin
        int t;
        logic [31:0] a;
        rst = 1'b1;
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
        ch_rd_valid = '0; ch_rd_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_awready", bus.awready, 1);
        check("rst_wready", bus.wready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_strobes", {ch_wr_en, ch_rd_en}, 0);
        check("rst_ch_outputs", {ch_wr_addr, ch_wr_data, ch_wr_strb, ch_rd_addr}, 0);

        do_write(32'h0000_1004, 32'hA5A5_0001, 4'hF, 0, 3, 0);
        do_write(32'h0000_2010, 32'h5A5A_0002, 4'h3, 3, 0, 2);
        do_write(32'h0000_0020, 32'h0000_0003, 4'h1, 0, 0, 1);
        do_read(32'h0000_2008, 5, 32'h1234_5678, 4, 1'b0);
        do_read(32'h0000_3000, 3, 32'hDEAD_BEEF, 0, 1'b0);
        do_write(32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(32'h0000_1000, 20, 32'hBAD0_BAD0, 5, 1'b0);
        do_read(32'h0000_1004, 3, 32'h0BAD_F00D, 0, 1'b0);
        do_read(32'h0000_0010, TO, 32'hCAFE_0016, 0, 1'b1);
        do_read(32'h0000_0014, TO + 1, 32'hCAFE_0017, 0, 1'b0);
        do_read(32'h0000_2000, 0, 32'h0, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, TO + 4), $urandom, $urandom_range(0, 3),
                        1'($urandom_range(0, 1)));
        end

        // Reset with a write parked in its response phase and a read stalled waiting.
        bus.awaddr = 32'h0000_1000; bus.wdata = 32'h1111_1111; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        t = 0;
        while (!bus.bvalid && t < 20) begin tick(); t++; end
        rd_lat_cfg = 0;
        bus.araddr = 32'h0000_0004; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        repeat (3) tick();
        check("pre_rst_bvalid", bus.bvalid, 1);
        check("pre_rst_rvalid", bus.rvalid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        evq.delete();
        check("mid_rst_bvalid", bus.bvalid, 0);
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        t = wr_en_cnt + rd_en_cnt;
        repeat (20) tick();
        check("post_rst_no_strobes", wr_en_cnt + rd_en_cnt - t, 0);
        check("post_rst_no_resp", {bus.bvalid, bus.rvalid}, 0);
        do_write(32'h0000_2044, 32'h7777_8888, 4'hC, 1, 0, 0);
        do_read(32'h0000_0044, 2, 32'h9999_AAAA, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
